// File: rtl/lif_tdm_scheduler.sv
// Time-multiplexed scheduler driving one shared combinational LIF core across N virtual neurons.
// A tick divider starts each sweep; neurons are issued in order and their results written back.

module lif_tdm_lane #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         issue,
  input  logic         wb,
  input  logic [W-1:0] wb_data,
  output logic [W-1:0] mem,
  output logic [W-1:0] cur
);
  logic [W:0] sum;

  assign sum = {1'b0, cur} + {1'b0, wr_data};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem <= '0;
      cur <= '0;
    end else begin
      if (wb) mem <= wb_data;
      // The core consumes cur during issue; a same-cycle write replaces it for the next sweep.
      if (issue)      cur <= wr_en ? wr_data : '0;
      else if (wr_en) cur <= sum[W] ? {W{1'b1}} : sum[W-1:0];
    end
  end
endmodule

module lif_tdm_scheduler #(
  parameter int N        = 4,
  parameter int W        = 8,
  parameter int TICK_DIV = 16,
  parameter int ID_W     = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            in_valid,
  input  logic [ID_W-1:0] in_id,
  input  logic [W-1:0]    in_current,
  input  logic            clr_ovr,
  output logic            core_valid,
  output logic [W-1:0]    core_state,
  output logic [W-1:0]    core_current,
  input  logic [W-1:0]    core_next,
  input  logic            core_spike,
  output logic            spike_valid,
  output logic [ID_W-1:0] spike_id,
  output logic            sweep_done,
  output logic            busy,
  output logic            overrun,
  input  logic [ID_W-1:0] rd_id,
  output logic [W-1:0]    rd_state
);
  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(N - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WB, DONE} state_t;

  state_t               state_q, state_d;
  logic [ID_W-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]     cnt;
  logic                 tick;
  logic [W-1:0]         next_r;
  logic                 spike_r;
  logic [N-1:0][W-1:0]  mem, cur;
  logic [N-1:0]         lane_wr, lane_issue, lane_wb;

  // Tick divider
  always_ff @(posedge clk) begin
    if (!rst_n)          cnt <= '0;
    else if (en)         cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
  end

  assign tick = en && (cnt == CNT_LAST);

  // Per-neuron state
  for (genvar g = 0; g < N; g++) begin : g_lane
    assign lane_wr[g]    = in_valid && (in_id == ID_W'(g));
    assign lane_issue[g] = (state_q == ISSUE) && (idx_q == ID_W'(g));
    assign lane_wb[g]    = (state_q == WB) && (idx_q == ID_W'(g));

    lif_tdm_lane #(.W(W)) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (lane_wr[g]),
      .wr_data (in_current),
      .issue   (lane_issue[g]),
      .wb      (lane_wb[g]),
      .wb_data (next_r),
      .mem     (mem[g]),
      .cur     (cur[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      next_r  <= '0;
      spike_r <= 1'b0;
      overrun <= 1'b0;
      rd_state <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (state_q == ISSUE) begin
        next_r  <= core_next;
        spike_r <= core_spike;
      end
      // A dropped tick outranks a simultaneous clear.
      if (tick && state_q != IDLE) overrun <= 1'b1;
      else if (clr_ovr)            overrun <= 1'b0;
      rd_state <= (int'(rd_id) < N) ? mem[rd_id] : '0;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    core_valid   = 1'b0;
    core_state   = '0;
    core_current = '0;
    spike_valid  = 1'b0;
    spike_id     = '0;
    sweep_done   = 1'b0;
    case (state_q)
      IDLE: begin
        if (tick) begin
          state_d = ISSUE;
          idx_d   = '0;
        end
      end
      ISSUE: begin
        core_valid   = 1'b1;
        core_state   = mem[idx_q];
        core_current = cur[idx_q];
        state_d      = WB;
      end
      WB: begin
        spike_valid = spike_r;
        spike_id    = spike_r ? idx_q : '0;
        if (idx_q == ID_LAST) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = ISSUE;
        end
      end
      DONE: begin
        sweep_done = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);
endmodule
